// File: rtl/gerador_padroes_bits_1.sv
// Enumerates every WIDTH-bit pattern with exactly K ones, in ascending order,
// over a valid/ready stream. Define GERADOR_TOTAL_EN to add the per-run beat counter 'total'.
//
// state | meaning
// IDLE  | waiting for start; no beat presented
// GERA  | presenting saida; advances on each valid && ready handshake
module gerador_padroes_bits_1 #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    quant_um,
    output logic             busy,
    output logic [WIDTH-1:0] saida,
    output logic             valid,
    input  logic             ready,
    output logic             last,
    output logic             erro
`ifdef GERADOR_TOTAL_EN
    ,
    output logic [WIDTH:0]   total
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        GERA = 1'b1
    } estado_t;

    localparam logic [CW-1:0] K_MAX = CW'(WIDTH);

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic [CW-1:0]    k_q, k_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;
    logic             erro_q, erro_d;
    logic [WIDTH:0]   total_q, total_d;
    logic [WIDTH-1:0] prox;

    // Smallest K-ones value: K ones packed at the bottom.
    function automatic logic [WIDTH-1:0] menor(input logic [CW-1:0] k);
        logic [WIDTH:0] ones;
        ones = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
        return ones[WIDTH-1:0];
    endfunction

    // Largest K-ones value: K ones packed at the top.
    function automatic logic [WIDTH-1:0] maior(input logic [CW-1:0] k);
        logic [WIDTH:0] ones;
        logic [WIDTH:0] sh;
        ones = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
        sh   = ones << (K_MAX - k);
        return sh[WIDTH-1:0];
    endfunction

    // Next larger value with the same popcount. Add the lowest set bit to ripple
    // the lowest run of ones upward, then refill the dropped ones at the bottom.
    // The division of the classic formulation is a shift by the trailing-zero count.
    function automatic logic [WIDTH-1:0] sucessor(input logic [WIDTH-1:0] x);
        logic [WIDTH:0]  xe;
        logic [WIDTH:0]  c;
        logic [WIDTH:0]  r;
        logic [WIDTH:0]  dif;
        logic [WIDTH:0]  nxt;
        logic [CW-1:0]   tz;
        tz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                tz = CW'(i);
            end
        end
        xe  = {1'b0, x};
        c   = {{WIDTH{1'b0}}, 1'b1} << tz;
        r   = xe + c;
        dif = ((xe ^ r) >> tz) >> 2;
        nxt = r | dif;
        return nxt[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        saida_d = saida_q;
        k_d     = k_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        last_d  = last_q;
        erro_d  = 1'b0;
        total_d = total_q;
        prox    = saida_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (quant_um <= K_MAX) begin
                        state_d = GERA;
                        saida_d = menor(quant_um);
                        k_d     = quant_um;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        last_d  = (quant_um == '0) || (quant_um == K_MAX);
                        total_d = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            GERA: begin
                if (valid_q && ready) begin
                    total_d = total_q + {{WIDTH{1'b0}}, 1'b1};
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        prox    = sucessor(saida_q);
                        saida_d = prox;
                        last_d  = (prox == maior(k_q));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            saida_q <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            erro_q  <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            erro_q  <= erro_d;
            total_q <= total_d;
        end
    end

    assign busy  = busy_q;
    assign saida = saida_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign erro  = erro_q;

`ifdef GERADOR_TOTAL_EN
    assign total = total_q;
`else
    logic unused_total;
    assign unused_total = ^total_q;
`endif

endmodule

// File: tb/tb_gerador_padroes_bits_1.sv
// Bench for gerador_padroes_bits_1: scoreboard of enumerated K-ones patterns, random backpressure.
module tb_gerador_padroes_bits_1;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] quant_um;
    logic          busy;
    logic [W-1:0]  saida;
    logic          valid;
    logic          ready;
    logic          last;
    logic          erro;
`ifdef GERADOR_TOTAL_EN
    logic [W:0]    total;
`endif

    gerador_padroes_bits_1 #(.WIDTH(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .quant_um (quant_um),
        .busy     (busy),
        .saida    (saida),
        .valid    (valid),
        .ready    (ready),
        .last     (last),
        .erro     (erro)
`ifdef GERADOR_TOTAL_EN
        ,
        .total    (total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] v;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           beats    = 0;
    int           cur_k    = 0;
    logic         hold_p   = 1'b0;
    logic [W-1:0] hold_v   = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: a handshake is pending when valid && ready is seen mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (hold_p && valid) chk("hold_saida", 32'(saida), 32'(hold_v));
            hold_p = valid && !ready;
            hold_v = saida;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got saida %0h expected no beat", saida);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_saida", 32'(saida), 32'(e.v));
                    chk("beat_last", 32'(last), 32'(e.l));
                    chk("beat_popcount", 32'($countones(saida)), 32'(cur_k));
                end
                beats++;
            end
        end else begin
            hold_p = 1'b0;
        end
    end

    // Reference: all W-bit values in ascending order whose popcount is k.
    function automatic int build_expected(input int k);
        beat_t b;
        int    n = 0;
        exp_q.delete();
        for (int v = 0; v < (1 << W); v++) begin
            logic [W-1:0] vv;
            vv = v[W-1:0];
            if ($countones(vv) == k) begin
                b.v = vv;
                b.l = 1'b0;
                exp_q.push_back(b);
                n++;
            end
        end
        exp_q[exp_q.size() - 1].l = 1'b1;
        return n;
    endfunction

    // mode: 0 ready high, 1 random ready, 2 hold at 0x0B, 3 random + stray start, 4 reset after 10 beats
    task automatic run_k(input int k, input int mode);
        int           ncomb;
        int           cyc  = 0;
        logic         done = 1'b0;
        logic         pend;
        logic         bp   = 1'b0;
        logic [W-1:0] fin;
        ncomb = build_expected(k);
        cur_k = k;
        beats = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        quant_um = CW'(k);
        ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_valid", 32'(valid), 1);
        chk("first_busy", 32'(busy), 1);
        while (!done && cyc < 1000) begin
            if (mode == 4 && beats == 10) begin
                ready = 1'b0;
                reset = 1'b0;
                @(posedge clk); #1;
                chk("rst_valid", 32'(valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_last", 32'(last), 0);
                chk("rst_saida", 32'(saida), 0);
`ifdef GERADOR_TOTAL_EN
                chk("rst_total", 32'(total), 0);
`endif
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            if (mode == 2 && !bp && valid && saida == 8'h0B) begin
                ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("bp_saida", 32'(saida), 32'h0B);
                    chk("bp_valid", 32'(valid), 1);
                end
                bp = 1'b1;
            end
            ready = (mode == 1 || mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 3 && cyc == 5) begin
                start    = 1'b1;
                quant_um = 4'd5;
            end else begin
                start = 1'b0;
            end
            pend = valid && ready && last;
            fin  = saida;
            @(posedge clk); #1;
            cyc++;
            chk("erro_in_run", 32'(erro), 0);
            if (pend) begin
                chk("end_busy", 32'(busy), 0);
                chk("end_valid", 32'(valid), 0);
                chk("end_last", 32'(last), 0);
                chk("end_saida_hold", 32'(saida), 32'(fin));
                done = 1'b1;
            end
        end
        start = 1'b0;
        if (!done) chk("run_timeout", 32'(cyc), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("beat_count", 32'(beats), 32'(ncomb));
        if (mode == 2) chk("bp_seen", 32'(bp), 1);
`ifdef GERADOR_TOTAL_EN
        chk("total_end", 32'(total), 32'(ncomb));
`endif
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        quant_um = '0;
        ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_last", 32'(last), 0);
        chk("reset_erro", 32'(erro), 0);
        chk("reset_saida", 32'(saida), 0);
        reset = 1'b1;

        run_k(2, 0);
        run_k(0, 0);
        run_k(8, 0);

        // Out-of-range request: single-cycle erro, no run.
        ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        start    = 1'b1;
        quant_um = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("erro_pulse", 32'(erro), 1);
        chk("erro_valid", 32'(valid), 0);
        chk("erro_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("erro_clear", 32'(erro), 0);
        chk("erro_valid2", 32'(valid), 0);

        run_k(1, 0);
        run_k(3, 2);
        run_k(4, 3);
        run_k(4, 4);
        run_k(2, 1);
        repeat (3) run_k($urandom_range(0, W), 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
